// File: rtl/ddr_ctrl_pkg.sv
// Shared types and MIG port constants for the DDR read-path controllers.
package ddr_ctrl_pkg;

  localparam int MIG_MAX_BL = 64;
  localparam int MIG_BL_W   = 6;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE} rd_state_e;

endpackage

// File: rtl/rd_watchdog.sv
// Cycle watchdog for a read burst that is waiting on user_rd_end.
// Only built when RD_TIMEOUT_EN is defined.
`ifdef RD_TIMEOUT_EN
module rd_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge sclk) begin
    if (!rst_n || clear_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Fires during the TIMEOUT_CYC-th consecutive waiting cycle.
  assign expire_o = run_i && (cnt_q == LIMIT);

endmodule
`endif

// File: rtl/ddr_rd_req_sched.sv
// Frame read request scheduler for MIG port 3: splits a frame into bursts and
// only issues a burst once the read-data FIFO can absorb it. Macro: RD_TIMEOUT_EN.
module ddr_rd_req_sched
  import ddr_ctrl_pkg::*;
#(
  parameter int BURST_LEN   = MIG_MAX_BL,
  parameter int FIFO_DEPTH  = 512,
  parameter int FIFO_CW     = 10,
`ifdef RD_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 4096,
`endif
  parameter int LW          = 24
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic                calib_done,
  input  logic                enable,
  input  logic                frame_start,
  input  logic [LW-1:0]       frame_words,
  input  logic [FIFO_CW-1:0]  fifo_wr_count,
  input  logic                user_rd_end,
  output logic                rd_start,
  output logic [MIG_BL_W-1:0] rd_cmd_bl,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         burst_cnt,
  output logic                rd_err
);

  rd_state_e             state_q;
  logic [LW-1:0]         remaining_q;
  logic [15:0]           burst_cnt_q;
  logic                  rd_start_q;
  logic [MIG_BL_W-1:0]   rd_cmd_bl_q;
  logic                  frame_done_q;

  logic [LW-1:0]         blen;
  logic [FIFO_CW:0]      fifo_free;
  logic                  room_ok;

  // remaining_q is stable from CHECK through WAIT, so blen is valid in all three.
  assign blen      = (remaining_q > LW'(BURST_LEN)) ? LW'(BURST_LEN) : remaining_q;
  assign fifo_free = (FIFO_CW + 1)'(FIFO_DEPTH) - {1'b0, fifo_wr_count};
  assign room_ok   = (LW'(fifo_free) >= blen);

`ifdef RD_TIMEOUT_EN
  logic wd_expire;
  logic rd_err_q;

  rd_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rd_watchdog (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .clear_i (state_q == ISSUE),
    .run_i   (state_q == WAIT),
    .expire_o(wd_expire)
  );

  assign rd_err = rd_err_q;
`else
  assign rd_err = 1'b0;
`endif

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      burst_cnt_q  <= '0;
      rd_start_q   <= 1'b0;
      rd_cmd_bl_q  <= '0;
      frame_done_q <= 1'b0;
`ifdef RD_TIMEOUT_EN
      rd_err_q     <= 1'b0;
`endif
    end else begin
      rd_start_q   <= 1'b0;
      rd_cmd_bl_q  <= '0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start && calib_done && enable) begin
            remaining_q <= frame_words;
            burst_cnt_q <= '0;
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          if (remaining_q == '0) begin
            frame_done_q <= 1'b1;
            state_q      <= DONE;
          end else if (!enable) begin
            state_q <= IDLE;
          end else if (room_ok) begin
            rd_start_q  <= 1'b1;
            rd_cmd_bl_q <= MIG_BL_W'(blen - LW'(1));
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          burst_cnt_q <= burst_cnt_q + 16'd1;
          state_q     <= WAIT;
        end
        // enable is deliberately ignored here: a burst in flight must drain.
        WAIT: begin
          if (user_rd_end) begin
            remaining_q <= remaining_q - blen;
            state_q     <= CHECK;
          end
`ifdef RD_TIMEOUT_EN
          else if (wd_expire) begin
            rd_err_q <= 1'b1;
            state_q  <= IDLE;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_start   = rd_start_q;
  assign rd_cmd_bl  = rd_cmd_bl_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign burst_cnt  = burst_cnt_q;

endmodule
